// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer and a forwarding tap on the head entry.
// Optional stall-cycle counter on stall_cnt_o when EX_MEM_PERF_EN is defined.
module ex_mem_skid #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ex_inst_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [PC_W-1:0]       ex_inst_pc_i,
  output logic                  mem_inst_valid_o,
  input  logic                  mem_ready_i,
  output logic [REG_ADDR_W-1:0] mem_wd_o,
  output logic                  mem_wreg_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [PC_W-1:0]       mem_inst_pc_o,
  output logic                  fwd_wreg_o,
  output logic [REG_ADDR_W-1:0] fwd_wd_o,
  output logic [DATA_W-1:0]     fwd_wdata_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic [PC_W-1:0]       pc;
  } entry_t;

  state_t state_reg;
  entry_t main_reg;
  entry_t skid_reg;
  entry_t in_entry;
  logic   main_valid;
  logic   in_fire;
  logic   out_fire;

  assign ex_ready_o = (state_reg != FULL);
  assign main_valid = (state_reg != EMPTY);
  assign in_fire    = ex_inst_valid_i & ex_ready_o & ~rst;
  assign out_fire   = main_valid & mem_ready_i;

  // Register 0 is hardwired, so a write to it is never allowed to propagate.
  assign in_entry.wd    = ex_wd_i;
  assign in_entry.wreg  = ex_wreg_i & (ex_wd_i != '0);
  assign in_entry.wdata = ex_wdata_i;
  assign in_entry.pc    = ex_inst_pc_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_reg  <= in_entry;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_reg <= in_entry;
          end else if (in_fire) begin
            skid_reg  <= in_entry;
            state_reg <= FULL;
          end else if (out_fire) begin
            main_reg  <= '0;
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          // ex_ready_o is low here, so only a drain can happen.
          if (out_fire) begin
            main_reg  <= skid_reg;
            skid_reg  <= '0;
            state_reg <= ONE;
          end
        end
        default: begin
          state_reg <= EMPTY;
          main_reg  <= '0;
          skid_reg  <= '0;
        end
      endcase
    end
  end

  assign mem_inst_valid_o = main_valid;
  assign mem_wd_o         = main_valid ? main_reg.wd    : '0;
  assign mem_wreg_o       = main_reg.wreg & main_valid;
  assign mem_wdata_o      = main_valid ? main_reg.wdata : '0;
  assign mem_inst_pc_o    = main_valid ? main_reg.pc    : '0;

  // Only the head is forwarded; the skid entry is covered by decode stalling on ex_ready_o.
  assign fwd_wreg_o  = mem_wreg_o;
  assign fwd_wd_o    = mem_wd_o;
  assign fwd_wdata_o = mem_wdata_o;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && !mem_ready_i) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed, table-driven bench for ex_mem_skid; covers the stall counter when EX_MEM_PERF_EN is defined.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ex_inst_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic [31:0] ex_inst_pc_i;
  logic        mem_inst_valid_o;
  logic        mem_ready_i;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_inst_pc_o;
  logic        fwd_wreg_o;
  logic [4:0]  fwd_wd_o;
  logic [31:0] fwd_wdata_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ex_mem_skid #(.REG_ADDR_W(5), .DATA_W(32), .PC_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .ex_inst_valid_i  (ex_inst_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_wd_i          (ex_wd_i),
    .ex_wreg_i        (ex_wreg_i),
    .ex_wdata_i       (ex_wdata_i),
    .ex_inst_pc_i     (ex_inst_pc_i),
    .mem_inst_valid_o (mem_inst_valid_o),
    .mem_ready_i      (mem_ready_i),
    .mem_wd_o         (mem_wd_o),
    .mem_wreg_o       (mem_wreg_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_inst_pc_o    (mem_inst_pc_o),
    .fwd_wreg_o       (fwd_wreg_o),
    .fwd_wd_o         (fwd_wd_o),
    .fwd_wdata_o      (fwd_wdata_o)
`ifdef EX_MEM_PERF_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic        vld;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        mrdy;
    logic        e_rdy;
    logic        e_vld;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic f, input logic v,
                     input logic [4:0] wd, input logic wr, input logic [31:0] d,
                     input logic [31:0] pc, input logic mr,
                     input logic erdy, input logic evld, input logic [4:0] ewd,
                     input logic ewr, input logic [31:0] ed, input logic [31:0] epc);
    vec_t t;
    t.name = nm; t.rst = r; t.flush = f; t.vld = v; t.wd = wd; t.wreg = wr;
    t.wdata = d; t.pc = pc; t.mrdy = mr; t.e_rdy = erdy; t.e_vld = evld;
    t.e_wd = ewd; t.e_wreg = ewr; t.e_wdata = ed; t.e_pc = epc;
    vecs.push_back(t);
  endtask

  // Outputs expected with the buffer empty.
  task automatic add_empty(input string nm, input logic r, input logic f, input logic v,
                           input logic [4:0] wd, input logic wr, input logic [31:0] d,
                           input logic [31:0] pc, input logic mr);
    add(nm, r, f, v, wd, wr, d, pc, mr, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_outputs(input string nm, input logic erdy, input logic evld,
                               input logic [4:0] ewd, input logic ewr,
                               input logic [31:0] ed, input logic [31:0] epc);
    chk({nm, ".ex_ready"},   32'(ex_ready_o),       32'(erdy));
    chk({nm, ".mem_valid"},  32'(mem_inst_valid_o), 32'(evld));
    chk({nm, ".mem_wd"},     32'(mem_wd_o),         32'(ewd));
    chk({nm, ".mem_wreg"},   32'(mem_wreg_o),       32'(ewr));
    chk({nm, ".mem_wdata"},  mem_wdata_o,           ed);
    chk({nm, ".mem_pc"},     mem_inst_pc_o,         epc);
    chk({nm, ".fwd_wreg"},   32'(fwd_wreg_o),       32'(ewr));
    chk({nm, ".fwd_wd"},     32'(fwd_wd_o),         32'(ewd));
    chk({nm, ".fwd_wdata"},  fwd_wdata_o,           ed);
  endtask

  task automatic drive_idle();
    rst = 1'b0; flush_i = 1'b0; ex_inst_valid_i = 1'b0; ex_wd_i = 5'd0;
    ex_wreg_i = 1'b0; ex_wdata_i = 32'h0; ex_inst_pc_i = 32'h0; mem_ready_i = 1'b1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;

    // Single entry, then drained.
    add("single_push", 0, 0, 1, 5'd3, 1, 32'h12345678, 32'h1C000000, 1,
        1, 1, 5'd3, 1, 32'h12345678, 32'h1C000000);
    add_empty("single_drain", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // Back-pressure: A then B fill the buffer; a push while FULL is refused.
    add("bp_push_a", 0, 0, 1, 5'd5, 1, 32'hAAAA0000, 32'h100, 0,
        1, 1, 5'd5, 1, 32'hAAAA0000, 32'h100);
    add("bp_push_b", 0, 0, 1, 5'd6, 1, 32'hBBBB0000, 32'h104, 0,
        0, 1, 5'd5, 1, 32'hAAAA0000, 32'h100);
    add("bp_hold", 0, 0, 1, 5'd7, 1, 32'h77777777, 32'h1F0, 0,
        0, 1, 5'd5, 1, 32'hAAAA0000, 32'h100);
    add("bp_drain_a", 0, 0, 1, 5'd7, 1, 32'h77777777, 32'h1F0, 1,
        1, 1, 5'd6, 1, 32'hBBBB0000, 32'h104);
    add_empty("bp_drain_b", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // Streaming: each accepted entry is the head one cycle later.
    for (int k = 0; k < 8; k++) begin
      add($sformatf("stream_%0d", k), 0, 0, 1, 5'(k + 1), 1, 32'hA0000000 + 32'(k),
          32'h300 + 32'(4 * k), 1,
          1, 1, 5'(k + 1), 1, 32'hA0000000 + 32'(k), 32'h300 + 32'(4 * k));
    end
    add_empty("stream_end", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // Flush while FULL with a push of C offered.
    add("fl_push_a", 0, 0, 1, 5'd8, 1, 32'hC1, 32'h400, 0,
        1, 1, 5'd8, 1, 32'hC1, 32'h400);
    add("fl_push_b", 0, 0, 1, 5'd9, 1, 32'hC2, 32'h404, 0,
        0, 1, 5'd8, 1, 32'hC1, 32'h400);
    add_empty("fl_flush_c", 0, 1, 1, 5'd10, 1, 32'hCC, 32'h408, 0);
    add_empty("fl_after", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // Flush in ONE: the accepted push is discarded.
    add("fl1_push_d", 0, 0, 1, 5'd11, 1, 32'hD0, 32'h500, 0,
        1, 1, 5'd11, 1, 32'hD0, 32'h500);
    add_empty("fl1_flush_e", 0, 1, 1, 5'd12, 1, 32'hE0, 32'h504, 0);
    add_empty("fl1_after", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // r0 rule and plain wreg=0.
    add("r0_push", 0, 0, 1, 5'd0, 1, 32'hDEADBEEF, 32'h200, 0,
        1, 1, 5'd0, 0, 32'hDEADBEEF, 32'h200);
    add("nowreg_push", 0, 0, 1, 5'd7, 0, 32'h5555AAAA, 32'h204, 1,
        1, 1, 5'd7, 0, 32'h5555AAAA, 32'h204);
    add_empty("nowreg_drain", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);
    // Reset while FULL with a push offered.
    add("rs_push_f", 0, 0, 1, 5'd13, 1, 32'hF0, 32'h600, 0,
        1, 1, 5'd13, 1, 32'hF0, 32'h600);
    add("rs_push_g", 0, 0, 1, 5'd14, 1, 32'hF1, 32'h604, 0,
        0, 1, 5'd13, 1, 32'hF0, 32'h600);
    add_empty("rs_reset_h", 1, 0, 1, 5'd15, 1, 32'hF2, 32'h608, 0);
    add_empty("rs_after", 0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush_i = vecs[i].flush; ex_inst_valid_i = vecs[i].vld;
      ex_wd_i = vecs[i].wd; ex_wreg_i = vecs[i].wreg; ex_wdata_i = vecs[i].wdata;
      ex_inst_pc_i = vecs[i].pc; mem_ready_i = vecs[i].mrdy;
      @(posedge clk);
      #1;
      $display("vec %0d %s: valid=%0b wd=%0d wreg=%0b wdata=0x%08h pc=0x%08h ex_ready=%0b",
               i, vecs[i].name, mem_inst_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o,
               mem_inst_pc_o, ex_ready_o);
      check_outputs(vecs[i].name, vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_wd,
                    vecs[i].e_wreg, vecs[i].e_wdata, vecs[i].e_pc);
    end

`ifdef EX_MEM_PERF_EN
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("perf_reset", stall_cnt_o, 32'd0);
    rst = 1'b0; ex_inst_valid_i = 1'b1; ex_wd_i = 5'd1; ex_wreg_i = 1'b1;
    ex_wdata_i = 32'h1; ex_inst_pc_i = 32'h700; mem_ready_i = 1'b0;
    @(posedge clk); #1;
    chk("perf_after_push", stall_cnt_o, 32'd0);
    ex_inst_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("perf: stall_cnt=%0d after 5 stalled cycles", stall_cnt_o);
    chk("perf_stall5", stall_cnt_o, 32'd5);
    flush_i = 1'b1;
    @(posedge clk); #1;
    chk("perf_flush_keeps", stall_cnt_o, 32'd6);
    flush_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("perf_rst_clears", stall_cnt_o, 32'd0);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Pipeline boundary between the execute stage and the memory stage.
- Captures each execute result (destination register, write enable, write data, pc) and presents it to the memory stage.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so a memory-stage stall never drops an in-flight result.
- Also exports the head entry as a forwarding source for decode.

Parameters:
REG_ADDR_W, 5, destination register index width
DATA_W, 32, result data width
PC_W, 32, instruction address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  discard all held entries (branch/exception)
ex_inst_valid_i  in  1  execute result valid
ex_ready_o  out  1  buffer can accept an execute result this cycle
ex_wd_i  in  REG_ADDR_W  destination register
ex_wreg_i  in  1  register write enable
ex_wdata_i  in  DATA_W  result data
ex_inst_pc_i  in  PC_W  instruction pc
mem_inst_valid_o  out  1  head entry valid
mem_ready_i  in  1  memory stage accepts the head this cycle
mem_wd_o  out  REG_ADDR_W  head destination register
mem_wreg_o  out  1  head write enable, gated by valid
mem_wdata_o  out  DATA_W  head data
mem_inst_pc_o  out  PC_W  head pc
fwd_wreg_o  out  1  forward enable (equals mem_wreg_o)
fwd_wd_o  out  REG_ADDR_W  forward register index
fwd_wdata_o  out  DATA_W  forward data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Storage: a main (head) register drives mem_*_o; a skid register holds a second entry.
- States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
- Handshake signals:
  - ex_ready_o = (state != FULL), combinational from state.
  - in_fire = ex_inst_valid_i & ex_ready_o & ~rst.
  - out_fire = mem_inst_valid_o & mem_ready_i.
- Transitions, priority order:
  1. rst: state EMPTY; all main/skid fields cleared to 0.
  2. flush_i: state EMPTY; all main/skid fields cleared to 0. An in_fire in the same cycle is discarded.
  3. EMPTY: in_fire loads main, goes to ONE.
  4. ONE, in_fire & out_fire: main reloads from the inputs, stays ONE.
  5. ONE, in_fire & ~out_fire: loads skid, goes to FULL.
  6. ONE, ~in_fire & out_fire: goes to EMPTY; main fields cleared.
  7. FULL: no in_fire is possible. out_fire moves skid into main, clears skid, goes to ONE.
  8. Otherwise: hold.
- Latency: an entry accepted on edge N appears on mem_*_o after edge N (1 cycle) when the buffer was EMPTY, or when it was ONE with out_fire.
- Ordering: strict FIFO; entries are never reordered.
- Throughput: 1 entry/cycle sustained while mem_ready_i=1.
- r0 rule: ex_wd_i == 0 forces the captured wreg to 0 (register 0 is hardwired).
- Output rules:
  - mem_wreg_o = main_wreg & main_valid.
  - mem_wd_o, mem_wdata_o and mem_inst_pc_o are 0 whenever the head is not valid.
- Reset values: mem_inst_valid_o=0, mem_wreg_o=0, mem_wd_o=0, mem_wdata_o=0, mem_inst_pc_o=0, fwd_*=0. ex_ready_o=1 once reset is released.
- Forwarding: fwd_* is combinational from the main register only. The skid entry is not forwarded; decode must stall when ex_ready_o=0.
- Data width: pure capture, no arithmetic; all fields are stored at full width.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], counting cycles where mem_inst_valid_o=1 and mem_ready_i=0.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst only; unaffected by flush_i.
- When undefined: the port and counter are absent; no other behaviour changes.

Test Plan:
- Reset, then a single entry: push wd=3, wreg=1, wdata=0x12345678, pc=0x1C000000 with mem_ready_i=1 -> next cycle mem_inst_valid_o=1 with the same fields; the following cycle valid=0 and all fields 0.
- Back-pressure: mem_ready_i=0; push A (pc=0x100), then B (pc=0x104) -> ex_ready_o=0 after B is accepted and the head stays A. Raise mem_ready_i -> A, then B, appear in order; ex_ready_o returns to 1 after A drains.
- Streaming: 8 consecutive pushes with mem_ready_i=1 -> 8 outputs on consecutive cycles, none lost or reordered, ex_ready_o held at 1.
- Flush while FULL, with a simultaneous push of C -> next cycle mem_inst_valid_o=0, EMPTY, and C never appears.
- r0 rule: push wd=0, wreg=1, wdata=0xDEADBEEF -> mem_wreg_o=0 and fwd_wreg_o=0.
- EX_MEM_PERF_EN defined: hold mem_ready_i=0 for 5 cycles with the head valid -> stall_cnt_o=5. Apply rst -> stall_cnt_o=0.
